// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Writes land in a small FIFO, and a frame FSM drains the FIFO onto TXD.
// Back-to-back frames follow each other with no idle gap while data is queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 TXD
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 full_q, empty_q, ovf_q;
    logic                 push, pop;

    // ---------------- Frame FSM ----------------
    state_t               state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q, txd_q, busy_q;
    logic [DATA_BITS-1:0] head;
    logic                 head_par, baud_last, stop_last, line;

    assign head      = mem_q[rptr_q];
    assign head_par  = (PARITY == 1) ? ~^head : ^head;
    assign baud_last = (baud_q == CW'(DIV - 1));
    assign stop_last = (state_q == S_STOP) && baud_last && (bit_q == BW'(STOP_BITS - 1));

    // A write while full is rejected even if a pop happens on the same edge.
    assign push = wr_en && !full_q;
    assign pop  = !empty_q && ((state_q == S_IDLE) || stop_last);

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign TXD      = txd_q;

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge CLK100MHZ) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    // Pointers, count and registered full/empty/overflow flags.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(FIFO_DEPTH));
            empty_q <= (cnt_d == '0);
            if (wr_en && full_q) ovf_q <= 1'b1;
        end
    end

    // Line level implied by the current state; registered into TXD.
    always_comb begin
        line = 1'b1;
        case (state_q)
            S_START: line = 1'b0;
            S_DATA:  line = shreg_q[0];
            S_PAR:   line = par_q;
            default: line = 1'b1;
        endcase
    end

    // Frame sequencer: baud counter, bit counter, shift register, TXD and busy.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            txd_q  <= line;
            baud_q <= (state_q == S_IDLE || baud_last) ? '0 : baud_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!empty_q) begin
                        shreg_q <= head;
                        par_q   <= head_par;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (baud_last) begin
                        shreg_q <= shreg_q >> 1;
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (baud_last) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (baud_last) begin
                        if (bit_q == BW'(STOP_BITS - 1)) begin
                            bit_q <= '0;
                            if (!empty_q) begin
                                // Chain straight into the next frame.
                                shreg_q <= head;
                                par_q   <= head_par;
                                state_q <= S_START;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at DIV=100,
// FIFO_DEPTH=4. Accepted bytes go into a scoreboard queue; a line decoder
// pops them and checks every cycle of every bit against the expected level.
module tb_uart_tx_fifo;
    localparam int DIV = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr_en;
    logic [7:0] wdat;
    logic [3:0] full, empty, busy, ovf, txd;

    int DB[4] = '{8, 8, 8, 7};
    int PM[4] = '{0, 2, 1, 0};
    int SB[4] = '{1, 1, 1, 2};

    logic [7:0] expq[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .CLK100MHZ(clk), .reset(rst), .wr_en(wr_en[0]), .wr_data(wdat),
        .full(full[0]), .empty(empty[0]), .busy(busy[0]), .overflow(ovf[0]), .TXD(txd[0]));
    uart_tx_fifo #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .CLK100MHZ(clk), .reset(rst), .wr_en(wr_en[1]), .wr_data(wdat),
        .full(full[1]), .empty(empty[1]), .busy(busy[1]), .overflow(ovf[1]), .TXD(txd[1]));
    uart_tx_fifo #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .CLK100MHZ(clk), .reset(rst), .wr_en(wr_en[2]), .wr_data(wdat),
        .full(full[2]), .empty(empty[2]), .busy(busy[2]), .overflow(ovf[2]), .TXD(txd[2]));
    uart_tx_fifo #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .CLK100MHZ(clk), .reset(rst), .wr_en(wr_en[3]), .wr_data(wdat[6:0]),
        .full(full[3]), .empty(empty[3]), .busy(busy[3]), .overflow(ovf[3]), .TXD(txd[3]));

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write; the byte is queued as expected output when it should be accepted.
    task automatic wr(input int idx, input logic [7:0] d, input bit accept);
        if (accept) expq.push_back(d);
        wr_en[idx] = 1'b1;
        wdat       = d;
        tick();
        wr_en[idx] = 1'b0;
        wdat       = 'x;
    endtask

    function automatic int flen(input int idx);
        return (1 + DB[idx] + ((PM[idx] != 0) ? 1 : 0) + SB[idx]) * DIV;
    endfunction

    // Expected line level for bit slot i of a frame carrying d.
    function automatic logic exp_bit(input int idx, input logic [7:0] d, input int i);
        int ones = 0;
        if (i == 0) return 1'b0;
        if (i <= DB[idx]) return d[i-1];
        if (PM[idx] != 0 && i == DB[idx] + 1) begin
            for (int j = 0; j < DB[idx]; j++) ones += int'(d[j]);
            if (PM[idx] == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    // Decode nfr frames. lat0 = edges until the first low sample; later frames
    // must start exactly exp_gap idle cycles after the previous stop bit.
    task automatic rx_frames(input int idx, input int nfr, input int first_max,
                             input int exp_gap, output int lat0, output int bcnt);
        lat0 = 0;
        bcnt = 0;
        for (int f = 0; f < nfr; f++) begin
            int n;
            int lim;
            int bad;
            logic [7:0] d;
            n   = 0;
            lim = (f == 0) ? first_max : exp_gap + 2;
            do begin
                tick();
                n++;
                if (busy[idx]) bcnt++;
            end while (txd[idx] && n < lim);
            if (txd[idx]) begin
                chk("start_timeout", n, -1);
                return;
            end
            if (f == 0) lat0 = n;
            else chk("gap", n - 1, exp_gap);
            if (expq.size() == 0) begin
                chk("sb_underrun", 0, 1);
                return;
            end
            d = expq.pop_front();
            for (int b = 0; b < flen(idx) / DIV; b++) begin
                bad = 0;
                for (int c = 0; c < DIV; c++) begin
                    if (b > 0 || c > 0) begin
                        tick();
                        if (busy[idx]) bcnt++;
                    end
                    if (txd[idx] !== exp_bit(idx, d, b)) bad++;
                end
                chk($sformatf("u%0d byte %02h bit %0d bad cycles", idx, d, b), bad, 0);
            end
        end
    endtask

    // Single-frame scenario: latency, content, busy length, and idle flags after.
    task automatic single(input int idx, input logic [7:0] d);
        int lat, bc;
        wr(idx, d, 1'b1);
        rx_frames(idx, 1, 10, 0, lat, bc);
        chk($sformatf("u%0d latency", idx), lat, 2);
        tick();
        chk($sformatf("u%0d busy cycles", idx), bc, flen(idx));
        chk($sformatf("u%0d empty after", idx), empty[idx], 1);
        chk($sformatf("u%0d busy after", idx), busy[idx], 0);
        chk($sformatf("u%0d txd idle", idx), txd[idx], 1);
    endtask

    // Second write timed relative to the first frame's final stop cycle.
    task automatic stop_edge(input int off, input int gap);
        int lat, bc;
        fork
            begin
                wr(0, 8'h3C, 1'b1);
                repeat (off - 1) tick();
                wr(0, 8'hC3, 1'b1);
            end
            rx_frames(0, 2, 10, gap, lat, bc);
        join
        tick();
        chk("stop_edge empty", empty[0], 1);
    endtask

    initial begin
        int lat, bc, lows;
        wr_en = '0;
        wdat  = '0;
        rst   = 1'b1;
        repeat (3) tick();
        chk("rst txd", txd[0], 1);
        chk("rst busy", busy[0], 0);
        chk("rst empty", empty[0], 1);
        chk("rst full", full[0], 0);
        chk("rst ovf", ovf[0], 0);
        rst = 1'b0;
        tick();

        single(0, 8'h55);
        single(1, 8'h07);
        single(2, 8'h07);
        single(3, 8'h7F);

        // Six back-to-back writes into a depth-4 FIFO while idle.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr(0, 8'hA0 + 8'(i), i < 5);
                    if (i == 3) chk("full after 4th", full[0], 0);
                    if (i == 4) chk("full after 5th", full[0], 1);
                    if (i == 4) chk("ovf after 5th", ovf[0], 0);
                    if (i == 5) chk("ovf after 6th", ovf[0], 1);
                end
            end
            rx_frames(0, 5, 10, 0, lat, bc);
        join
        chk("burst busy cycles", bc, 5 * flen(0));
        tick();
        chk("burst empty", empty[0], 1);
        chk("burst busy", busy[0], 0);
        chk("burst ovf sticky", ovf[0], 1);
        chk("burst sb drained", expq.size(), 0);

        stop_edge(1000, 0);
        stop_edge(1001, 1);

        // Reset in the middle of data bit 3 with two entries queued.
        wr(0, 8'h55, 1'b0);
        wr(0, 8'h11, 1'b0);
        wr(0, 8'h22, 1'b0);
        repeat (450) tick();
        chk("mid bit3 level", txd[0], 0);
        chk("mid busy", busy[0], 1);
        chk("mid ovf", ovf[0], 1);
        chk("mid empty", empty[0], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort txd", txd[0], 1);
        chk("abort busy", busy[0], 0);
        chk("abort empty", empty[0], 1);
        chk("abort full", full[0], 0);
        chk("abort ovf", ovf[0], 0);
        lows = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!txd[0] || busy[0]) lows++;
        end
        chk("post-abort quiet cycles", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
